tx_axis_framer: RTL
===================

Name: tx_axis_framer

Overview:
- Transmit-side framer between the tx AHIR pipe and the MAC tx AXI-stream port, running on the 125 MHz MAC clock domain.
- Consumes 10-bit pipe words in the format {last, byte[7:0], 1'b0} and emits byte-wide AXI-stream beats with tlast.
- Zero-pads short frames to the Ethernet minimum (60 bytes; the MAC appends FCS).
- Counts transmitted frames. Inverse of the rx path, which packs AXI-stream beats into pipe words.

Parameters:
MIN_LEN, 60, minimum frame length in bytes excluding FCS; 0 or 1 disables padding
MAX_LEN, 1514, maximum frame length in bytes; used only with TX_MAXLEN_EN
CNT_W, 11, width of the per-frame byte counter; must satisfy 2^CNT_W > max(MIN_LEN, MAX_LEN)

Ports:
clk  in  1  MAC clock (125 MHz)
reset  in  1  asynchronous reset, active-low (0 = reset)
tx_pipe_data  in  10  pipe word: bit9 = last, bits8:1 = byte, bit0 reserved/ignored
tx_pipe_ack  in  1  pipe word valid
tx_pipe_req  out  1  framer ready; word transfers when ack && req
tx_axis_tdata  out  8  output byte
tx_axis_tvalid  out  1  output beat valid
tx_axis_tready  in  1  MAC ready
tx_axis_tlast  out  1  last beat of frame
tx_axis_tuser  out  1  abort/bad frame; constant 0 without TX_MAXLEN_EN
frame_count  out  16  completed frames, wraps 0xFFFF -> 0
pad_active  out  1  high while in PAD state

Behaviour:
- Reset (reset = 0, async assert, sync release): tvalid = 0, tdata = 0, tlast = 0, tuser = 0, tx_pipe_req = 0, frame_count = 0, byte counter = 0, state = IDLE. A frame in flight is discarded with no tlast emitted.
- Output beat register: one entry.
  - "slot free" = !tvalid || tready.
  - AXI rule: once tvalid is high, tdata, tlast and tuser are held until tready.
- States:
  - IDLE / DATA: tx_pipe_req = slot free. An accepted word loads the output register the next edge, so tvalid rises 1 cycle after the accept; byte counter +1. Full throughput is 1 byte/cycle while tready = 1.
    - Accepted word with last = 0: go to or stay in DATA.
    - Accepted word with last = 1 and count+1 >= MIN_LEN: tlast = 1 on that beat; counter cleared; go to IDLE.
    - Accepted word with last = 1 and count+1 < MIN_LEN: beat emitted with tlast = 0; go to PAD.
  - PAD: tx_pipe_req = 0. Each time the slot is free, load tdata = 0x00 and increment the counter. The beat that brings the count to MIN_LEN has tlast = 1; counter cleared; go to IDLE.
- frame_count increments on the cycle the tlast beat handshakes (tvalid && tready && tlast), including aborted frames.
- Byte counter saturates at 2^CNT_W-1 and never wraps.
- Boundaries:
  - A frame of exactly MIN_LEN bytes gets no padding.
  - A 1-byte frame gets MIN_LEN-1 pad bytes.
  - tready held low stalls DATA and PAD indefinitely with outputs stable.
  - tx_pipe_ack with tx_pipe_req = 0: no transfer, the word stays on the pipe.
  - Back-to-back frames: the first byte of the next frame may be accepted in the same cycle the previous tlast beat handshakes.

Optional Feature:
- Macro: TX_MAXLEN_EN.
- Defined:
  - If a word is accepted with last = 0 and it is byte MAX_LEN, that beat is emitted with tlast = 1 and tuser = 1, and the state goes to DROP.
  - DROP: tx_pipe_req = 1; words are accepted and discarded until a word with last = 1 is accepted, then go to IDLE.
  - A word with last = 1 at byte MAX_LEN is a normal end: tuser = 0.
- Not defined: no length limit, no DROP state; tuser tied to 0.

Test Plan:
- 64-byte frame 0x00..0x3F, tready = 1 -> 64 beats, tlast only on 0x3F, no pad, frame_count = 1, first tvalid 1 cycle after the first accept.
- 1-byte frame 0xA5 -> beat 0xA5 then 59 beats of 0x00, tlast on beat 60, pad_active high for the pad beats, frame_count = 1.
- 60-byte frame with tready toggling every other cycle -> exactly 60 beats, data order intact, tdata held during stalls, no pad.
- Two 10-byte frames back-to-back -> two 60-byte output frames; byte 1 of frame 2 accepted in the same cycle as frame 1's tlast handshake; frame_count = 2.
- Reset pulsed low at byte 30 of a frame -> outputs 0 asynchronously; after release, a new 60-byte frame transmits cleanly and frame_count = 1.
- TX_MAXLEN_EN, MAX_LEN = 100, 150-byte frame -> 100 beats, beat 100 has tlast = 1 and tuser = 1; remaining 50 words consumed with no output; next frame is normal.

Source files
------------

// File: rtl/tx_axis_framer_if.sv
// rtl/tx_axis_framer_if.sv - pipe-side and AXI-stream-side handshake bundle for the tx framer
interface tx_axis_framer_if;
    logic [9:0] tx_pipe_data;
    logic       tx_pipe_ack;
    logic       tx_pipe_req;
    logic [7:0] tx_axis_tdata;
    logic       tx_axis_tvalid;
    logic       tx_axis_tready;
    logic       tx_axis_tlast;
    logic       tx_axis_tuser;

    modport master (
        input  tx_pipe_data, tx_pipe_ack, tx_axis_tready,
        output tx_pipe_req, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser
    );

    modport slave (
        output tx_pipe_data, tx_pipe_ack, tx_axis_tready,
        input  tx_pipe_req, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser
    );
endinterface

// File: rtl/tx_axis_framer.sv
// rtl/tx_axis_framer.sv - pipe words to byte AXI-stream with min-length zero padding; TX_MAXLEN_EN adds length limit/drop
module tx_axis_framer #(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               reset,
    tx_axis_framer_if.master   tx,
    output logic [15:0]        frame_count,
    output logic               pad_active
);

`ifdef TX_MAXLEN_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_DROP} state_t;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
    logic       tuser_q, tuser_d;
    logic       unused_ok;
    assign unused_ok = tx.tx_pipe_data[0];
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;
    logic       unused_ok;
    assign unused_ok = ^{tx.tx_pipe_data[0], 32'(MAX_LEN)};
`endif

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [15:0]        fc_q;
    logic               en_q;
    logic               slot_free, req, accept, in_last;
    logic [7:0]         in_byte;

    assign slot_free = !tvalid_q || tx.tx_axis_tready;
    assign accept    = tx.tx_pipe_ack && req;
    assign in_last   = tx.tx_pipe_data[9];
    assign in_byte   = tx.tx_pipe_data[8:1];
    // saturating increment: a runaway frame must never wrap back under MIN_LEN
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // next state, pipe ready and output-beat loading
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q && !tx.tx_axis_tready;
        req      = 1'b0;
`ifdef TX_MAXLEN_EN
        tuser_d  = tuser_q;
`endif
        case (state_q)
            S_IDLE, S_DATA: begin
                req = en_q && slot_free;
                if (accept) begin
                    tvalid_d = 1'b1;
                    tdata_d  = in_byte;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_inc;
`ifdef TX_MAXLEN_EN
                    tuser_d  = 1'b0;
`endif
                    if (in_last) begin
                        if (cnt_inc >= MIN_C) begin
                            tlast_d = 1'b1;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_PAD;
                        end
`ifdef TX_MAXLEN_EN
                    end else if (cnt_inc == MAX_C) begin
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DROP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_PAD: begin
                if (slot_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = 8'h00;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_inc;
`ifdef TX_MAXLEN_EN
                    tuser_d  = 1'b0;
`endif
                    if (cnt_inc >= MIN_C) begin
                        tlast_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef TX_MAXLEN_EN
            S_DROP: begin
                req = en_q;
                if (accept && in_last) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters and the single output beat register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            fc_q     <= 16'h0000;
            en_q     <= 1'b0;
`ifdef TX_MAXLEN_EN
            tuser_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            en_q     <= 1'b1;
`ifdef TX_MAXLEN_EN
            tuser_q  <= tuser_d;
`endif
            if (tvalid_q && tx.tx_axis_tready && tlast_q) begin
                fc_q <= fc_q + 16'd1;
            end
        end
    end

    assign tx.tx_pipe_req    = req;
    assign tx.tx_axis_tdata  = tdata_q;
    assign tx.tx_axis_tvalid = tvalid_q;
    assign tx.tx_axis_tlast  = tlast_q;
`ifdef TX_MAXLEN_EN
    assign tx.tx_axis_tuser  = tuser_q;
`else
    assign tx.tx_axis_tuser  = 1'b0;
`endif
    assign frame_count       = fc_q;
    assign pad_active        = (state_q == S_PAD);

endmodule
